// File: rtl/boss_pkg.sv
// Shared phase encoding and default boss geometry/threshold constants used by
// the phase controller, the sprite renderer and the damage logic.
package boss_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ENTER   = 3'd1,
        PH_DESCEND = 3'd2,
        PH_RETREAT = 3'd3,
        PH_DEAD    = 3'd4
    } phase_t;

    localparam int DEF_N_ENEMY   = 4;
    localparam int DEF_COORD_W   = 10;
    localparam int DEF_HP_W      = 10;
    localparam int DEF_X_START   = 0;
    localparam int DEF_Y_START   = 75;
    localparam int DEF_X_STOP    = 400;
    localparam int DEF_Y_LOW     = 150;
    localparam int DEF_X_MIN     = 50;
    localparam int DEF_STEP_X    = 5;
    localparam int DEF_STEP_Y    = 1;
    localparam int DEF_P1_THR    = 300;
    localparam int DEF_P2_THR    = 150;
    localparam int DEF_FLASH_LEN = 8;

    // Visible and hittable phases.
    function automatic logic is_active(input phase_t p);
        return (p == PH_ENTER) || (p == PH_DESCEND) || (p == PH_RETREAT);
    endfunction

endpackage

// File: rtl/boss_phase_ctrl_if.sv
// Signal bundle between the game logic (master) and the boss phase controller
// (slave); the controller samples the inputs and returns registered outputs.
interface boss_phase_ctrl_if #(
    parameter int N_ENEMY = 4,
    parameter int COORD_W = 10,
    parameter int HP_W    = 10
);
    // No valid/ready pair here: enemy_alive and boss_hp are level inputs
    // sampled every clk22 edge, move_en is a one-cycle strobe that is consumed
    // on the edge where it is high, and all outputs are valid every cycle.
    logic [N_ENEMY-1:0] enemy_alive;
    logic [HP_W-1:0]    boss_hp;
    logic               move_en;
    logic [COORD_W-1:0] boss_x;
    logic [COORD_W-1:0] boss_y;
    logic               boss_active;
    logic [2:0]         phase;
    logic               hit_flash;
    logic               defeated;

    modport master (
        output enemy_alive, boss_hp, move_en,
        input  boss_x, boss_y, boss_active, phase, hit_flash, defeated
    );

    modport slave (
        input  enemy_alive, boss_hp, move_en,
        output boss_x, boss_y, boss_active, phase, hit_flash, defeated
    );
endinterface

// File: rtl/hit_flash_timer.sv
// Retriggerable down-counter: a trigger loads FLASH_LEN and the flash output
// stays high until the count has drained to zero; clear wins over trigger.
module hit_flash_timer #(
    parameter int FLASH_LEN = 8
) (
    input  logic clk22,
    input  logic rst,
    input  logic clear,
    input  logic trigger,
    output logic flash
);
    localparam int CW = $clog2(FLASH_LEN + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clear) begin
            cnt_d = '0;
        end else if (trigger) begin
            cnt_d = CW'(FLASH_LEN);
        end else if (cnt != '0) begin
            cnt_d = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            flash <= 1'b0;
        end else begin
            cnt   <= cnt_d;
            flash <= (cnt_d != '0);
        end
    end
endmodule

// File: rtl/boss_phase_ctrl.sv
// Boss movement/phase controller: waits for all enemies to clear, then walks
// the boss through HP-driven phases with clamped moves, hit flash and defeat pulse.
module boss_phase_ctrl
    import boss_pkg::*;
#(
    parameter int N_ENEMY   = DEF_N_ENEMY,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int HP_W      = DEF_HP_W,
    parameter int X_START   = DEF_X_START,
    parameter int Y_START   = DEF_Y_START,
    parameter int X_STOP    = DEF_X_STOP,
    parameter int Y_LOW     = DEF_Y_LOW,
    parameter int X_MIN     = DEF_X_MIN,
    parameter int STEP_X    = DEF_STEP_X,
    parameter int STEP_Y    = DEF_STEP_Y,
    parameter int P1_THR    = DEF_P1_THR,
    parameter int P2_THR    = DEF_P2_THR,
    parameter int FLASH_LEN = DEF_FLASH_LEN
) (
    input  logic              clk22,
    input  logic              rst,
    boss_phase_ctrl_if.slave  bus
);
    localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
    localparam logic [COORD_W-1:0] Y_START_C = COORD_W'(Y_START);
    localparam logic [COORD_W:0]   X_STOP_E  = (COORD_W+1)'(X_STOP);
    localparam logic [COORD_W:0]   Y_LOW_E   = (COORD_W+1)'(Y_LOW);
    localparam logic [COORD_W:0]   X_MIN_E   = (COORD_W+1)'(X_MIN);
    localparam logic [COORD_W:0]   STEP_X_E  = (COORD_W+1)'(STEP_X);
    localparam logic [COORD_W:0]   STEP_Y_E  = (COORD_W+1)'(STEP_Y);
    localparam logic [HP_W-1:0]    P1_THR_C  = HP_W'(P1_THR);
    localparam logic [HP_W-1:0]    P2_THR_C  = HP_W'(P2_THR);

    phase_t             phase_q;
    phase_t             phase_d;
    phase_t             target;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_d;
    logic               active_q;
    logic               defeated_q;
    logic [HP_W-1:0]    prev_hp;
    logic               prev_valid;
    logic               hit;
    logic               flash_clear;

    // Add with one guard bit and clamp at the limit; also snaps values already past it.
    function automatic logic [COORD_W-1:0] step_up(input logic [COORD_W-1:0] v,
                                                   input logic [COORD_W:0]   step,
                                                   input logic [COORD_W:0]   lim);
        logic [COORD_W:0] sum;
        sum = {1'b0, v} + step;
        return (sum >= lim) ? lim[COORD_W-1:0] : sum[COORD_W-1:0];
    endfunction

    function automatic logic [COORD_W-1:0] step_down(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W:0]   step,
                                                     input logic [COORD_W:0]   lim);
        logic [COORD_W:0] diff;
        diff = {1'b0, v} - step;
        return (({1'b0, v} < step) || (diff <= lim)) ? lim[COORD_W-1:0] : diff[COORD_W-1:0];
    endfunction

    always_comb begin
        if (bus.boss_hp > P1_THR_C) begin
            target = PH_ENTER;
        end else if (bus.boss_hp > P2_THR_C) begin
            target = PH_DESCEND;
        end else if (bus.boss_hp != '0) begin
            target = PH_RETREAT;
        end else begin
            target = PH_DEAD;
        end
    end

    // Death beats enemy re-appearance; otherwise the phase only ever moves forward.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: begin
                if (bus.enemy_alive == {N_ENEMY{1'b0}}) begin
                    phase_d = PH_ENTER;
                end
            end
            PH_ENTER, PH_DESCEND, PH_RETREAT: begin
                if (target == PH_DEAD) begin
                    phase_d = PH_DEAD;
                end else if (|bus.enemy_alive) begin
                    phase_d = PH_IDLE;
                end else if (target > phase_q) begin
                    phase_d = target;
                end
            end
            PH_DEAD: phase_d = PH_DEAD;
            default: phase_d = PH_IDLE;
        endcase
    end

    // Moves follow the phase registered this cycle, not the one being entered.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (phase_d == PH_DEAD) begin
            x_d = '0;
            y_d = '0;
        end else if (phase_d == PH_IDLE) begin
            x_d = X_START_C;
            y_d = Y_START_C;
        end else if (bus.move_en) begin
            case (phase_q)
                PH_ENTER:   x_d = step_up(x_q, STEP_X_E, X_STOP_E);
                PH_DESCEND: y_d = step_up(y_q, STEP_Y_E, Y_LOW_E);
                PH_RETREAT: x_d = step_down(x_q, STEP_X_E, X_MIN_E);
                default: begin
                    x_d = x_q;
                    y_d = y_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk22 or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            x_q        <= X_START_C;
            y_q        <= Y_START_C;
            active_q   <= 1'b0;
            defeated_q <= 1'b0;
            prev_hp    <= '0;
            prev_valid <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            x_q        <= x_d;
            y_q        <= y_d;
            active_q   <= is_active(phase_d);
            defeated_q <= (phase_d == PH_DEAD) && (phase_q != PH_DEAD);
            prev_hp    <= bus.boss_hp;
            prev_valid <= 1'b1;
        end
    end

    // prev_valid suppresses a bogus hit before the first HP sample after reset.
    assign hit         = prev_valid && is_active(phase_q) && (bus.boss_hp < prev_hp);
    assign flash_clear = !is_active(phase_d);

    hit_flash_timer #(
        .FLASH_LEN (FLASH_LEN)
    ) u_flash (
        .clk22   (clk22),
        .rst     (rst),
        .clear   (flash_clear),
        .trigger (hit),
        .flash   (bus.hit_flash)
    );

    assign bus.boss_x      = x_q;
    assign bus.boss_y      = y_q;
    assign bus.boss_active = active_q;
    assign bus.phase       = phase_q;
    assign bus.defeated    = defeated_q;
endmodule

// File: tb/tb_boss_phase_ctrl.sv
// Directed bench for boss_phase_ctrl: the driver queues a hand-computed expected
// output word per cycle, and a monitor compares it one edge later.
module tb_boss_phase_ctrl;
    import boss_pkg::*;

    localparam int W = 26;  // {phase[3], x[10], y[10], active, flash, defeated}

    logic clk22 = 1'b0;
    logic rst;

    boss_phase_ctrl_if #(.N_ENEMY(4), .COORD_W(10), .HP_W(10)) bus ();

    boss_phase_ctrl dut (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk22 = ~clk22;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];
    int           n_vec = 0;
    int           n_bad = 0;

    function automatic logic [W-1:0] mk(input phase_t ph, input int x, input int y,
                                        input bit act, input bit fl, input bit df);
        return {ph, 10'(x), 10'(y), act, fl, df};
    endfunction

    // Called just after a falling edge; the queued word is the response after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] ea, input int hp, input logic mv,
                         input logic [W-1:0] e, input string tag);
        rst             = r;
        bus.enemy_alive = ea;
        bus.boss_hp     = 10'(hp);
        bus.move_en     = mv;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk22);
    endtask

    initial begin : monitor
        logic [W-1:0] e;
        logic [W-1:0] got;
        string        t;
        forever begin
            @(posedge clk22);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                t   = tag_q.pop_front();
                got = {bus.phase, bus.boss_x, bus.boss_y, bus.boss_active, bus.hit_flash, bus.defeated};
                n_vec++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL %s: got ph=%0d x=%0d y=%0d act=%0b fl=%0b df=%0b, required ph=%0d x=%0d y=%0d act=%0b fl=%0b df=%0b",
                             t, got[25:23], got[22:13], got[12:3], got[2], got[1], got[0],
                             e[25:23], e[22:13], e[12:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst             = 1'b1;
        bus.enemy_alive = 4'b0010;
        bus.boss_hp     = 10'd400;
        bus.move_en     = 1'b0;
        @(negedge clk22);

        // Reset state, then IDLE held while an enemy lives (move strobes ignored).
        for (int i = 0; i < 2; i++) drive(1, 4'b0010, 400, 0, mk(PH_IDLE, 0, 75, 0, 0, 0), "reset");
        for (int i = 0; i < 20; i++) drive(0, 4'b0010, 400, 1'(i), mk(PH_IDLE, 0, 75, 0, 0, 0), "idle_hold");
        drive(0, 4'b0000, 400, 0, mk(PH_ENTER, 0, 75, 1, 0, 0), "enter_on_clear");

        // ENTER: 5 per strobe, clamps at 400 from strobe 80.
        for (int k = 1; k <= 85; k++)
            drive(0, 4'b0000, 400, 1, mk(PH_ENTER, (5*k > 400) ? 400 : 5*k, 75, 1, 0, 0), "enter_move");

        // DESCEND: HP drop also triggers an 8-cycle flash.
        drive(0, 4'b0000, 200, 0, mk(PH_DESCEND, 400, 75, 1, 1, 0), "to_descend");
        for (int k = 1; k <= 100; k++)
            drive(0, 4'b0000, 200, 1, mk(PH_DESCEND, 400, (75+k > 150) ? 150 : 75+k, 1, k <= 7, 0), "descend_move");

        // RETREAT: x falls 5 per strobe to 50 at strobe 70.
        drive(0, 4'b0000, 120, 0, mk(PH_RETREAT, 400, 150, 1, 1, 0), "to_retreat");
        for (int k = 1; k <= 75; k++)
            drive(0, 4'b0000, 120, 1, mk(PH_RETREAT, (400-5*k < 50) ? 50 : 400-5*k, 150, 1, k <= 7, 0), "retreat_move");

        // Fresh run: skip ENTER -> RETREAT, heal keeps RETREAT, snap from x=0 up to X_MIN.
        for (int i = 0; i < 2; i++) drive(1, 4'b0000, 400, 0, mk(PH_IDLE, 0, 75, 0, 0, 0), "reset2");
        drive(0, 4'b0000, 400, 0, mk(PH_ENTER, 0, 75, 1, 0, 0), "enter2");
        drive(0, 4'b0000, 100, 0, mk(PH_RETREAT, 0, 75, 1, 1, 0), "skip_to_retreat");
        for (int k = 1; k <= 3; k++) drive(0, 4'b0000, 350, 0, mk(PH_RETREAT, 0, 75, 1, 1, 0), "heal_keeps");
        drive(0, 4'b0000, 350, 1, mk(PH_RETREAT, 50, 75, 1, 1, 0), "retreat_snap");

        // Enemy re-appears: back to IDLE at spawn, flash cleared, then re-armed.
        drive(0, 4'b0001, 350, 0, mk(PH_IDLE, 0, 75, 0, 0, 0), "enemy_back");
        drive(0, 4'b0000, 350, 0, mk(PH_ENTER, 0, 75, 1, 0, 0), "rearm");
        drive(0, 4'b0000, 350, 0, mk(PH_ENTER, 0, 75, 1, 0, 0), "rearm_hold");

        // Let the 350->300 flash expire, then retrigger: 300->290, 290->280 three cycles later.
        for (int k = 0; k < 10; k++)
            drive(0, 4'b0000, 300, 0, mk(PH_DESCEND, 0, 75, 1, k <= 7, 0), "flash_settle");
        for (int j = 0; j < 14; j++)
            drive(0, 4'b0000, (j < 3) ? 290 : 280, 0, mk(PH_DESCEND, 0, 75, 1, j <= 10, 0), "flash_retrig");

        // hp=0 with move_en and an enemy bit: DEAD wins, single defeat pulse.
        drive(0, 4'b0001, 0, 1, mk(PH_DEAD, 0, 0, 0, 0, 1), "dead_entry");
        for (int i = 0; i < 6; i++)
            drive(0, 4'(i), (i * 97) % 400, 1, mk(PH_DEAD, 0, 0, 0, 0, 0), "dead_terminal");
        drive(1, 4'b0000, 400, 0, mk(PH_IDLE, 0, 75, 0, 0, 0), "reset_from_dead");
        drive(0, 4'b1000, 400, 0, mk(PH_IDLE, 0, 75, 0, 0, 0), "idle_after_dead");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk22);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d checks left, 0 required", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
